wb_commit_stage: RTL



---
 rtl/wb_commit_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_stage
//  Description : Writeback/commit stage. Completed instructions from MEM are
//                held in a DEPTH-entry circular buffer and retired in program
//                order, one per cycle. Retirement drives the GPR, CSR,
//                exception and trace ports and advances the retired-instruction
//                counter. An exception or ertn at the head flushes the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_stage #(
    parameter int                   DEPTH     = 2,
    parameter int                   EXC_NUM   = 6,
    parameter logic [6*EXC_NUM-1:0] ECODE_TAB = {6'h09, 6'h0c, 6'h0b, 6'h0d, 6'h08, 6'h00},
    parameter logic [9*EXC_NUM-1:0] ESUB_TAB  = '0
) (
    input  logic                     clk,
    input  logic                     reset,

    // MEM -> WB handshake and payload
    input  logic                     ms_to_ws_valid,
    output logic                     ws_allowin,
    input  logic [31:0]              ms_pc,
    input  logic [31:0]              ms_result,
    input  logic                     ms_gr_we,
    input  logic [4:0]               ms_dest,
    input  logic [EXC_NUM-1:0]       ms_exc_flgs,
    input  logic                     ms_csr_we,
    input  logic [13:0]              ms_csr_wnum,
    input  logic [31:0]              ms_csr_wmask,
    input  logic [31:0]              ms_csr_wdata,
    input  logic                     ms_ertn,

    // Retirement hold
    input  logic                     commit_stall,

    // GPR write port
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,

    // CSR write port
    output logic                     csr_we,
    output logic [13:0]              csr_wnum,
    output logic [31:0]              csr_wmask,
    output logic [31:0]              csr_wval,

    // Exception / ertn reporting
    output logic                     wb_exc,
    output logic [5:0]               wb_ecode,
    output logic [8:0]               wb_esubcode,
    output logic [31:0]              wb_pc,
    output logic [31:0]              wb_badvaddr,
    output logic                     ertn_flush,

    // Hazard hints for earlier stages
    output logic                     ws_csr_blk_we,
    output logic                     ws_csr_blk_ertn,

    // Status
    output logic [$clog2(DEPTH):0]   ws_count,
    output logic [63:0]              instret,

    // Trace port
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        result;
        logic               gr_we;
        logic [4:0]         dest;
        logic [EXC_NUM-1:0] exc_flgs;
        logic               csr_we;
        logic [13:0]        csr_wnum;
        logic [31:0]        csr_wmask;
        logic [31:0]        csr_wdata;
        logic               ertn;
    } entry_t;

    // Buffer storage and pointers
    entry_t               r_buf [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [63:0]          r_instret;

    entry_t               w_in;
    entry_t               w_head;
    logic                 w_commit;
    logic                 w_allowin;
    logic                 w_enq;
    logic                 w_exc;
    logic                 w_rf_we;
    logic                 w_csr_we;
    logic                 w_ertn;
    logic                 w_flush;
    logic [5:0]           w_ecode;
    logic [8:0]           w_esub;
    logic                 w_blk_we;
    logic                 w_blk_ertn;

    // Pack the incoming MEM bus into one buffer entry
    always_comb begin
        w_in           = '0;
        w_in.pc        = ms_pc;
        w_in.result    = ms_result;
        w_in.gr_we     = ms_gr_we;
        w_in.dest      = ms_dest;
        w_in.exc_flgs  = ms_exc_flgs;
        w_in.csr_we    = ms_csr_we;
        w_in.csr_wnum  = ms_csr_wnum;
        w_in.csr_wmask = ms_csr_wmask;
        w_in.csr_wdata = ms_csr_wdata;
        w_in.ertn      = ms_ertn;
    end

    // Retire-side control: head selection, commit/exception/flush decode
    always_comb begin
        w_head    = r_buf[r_head];
        // Reset suppresses retirement so a mid-run reset leaves no retire pulse
        w_commit  = (r_count != '0) & ~commit_stall & ~reset;
        // A retire in the same cycle frees a slot of a full buffer
        w_allowin = (r_count < c_CNT_W'(DEPTH)) | w_commit;
        w_exc     = w_commit & (|w_head.exc_flgs);
        w_rf_we   = w_commit & w_head.gr_we  & ~w_exc;
        w_csr_we  = w_commit & w_head.csr_we & ~w_exc;
        // Exception takes priority over ertn on the same entry
        w_ertn    = w_commit & w_head.ertn   & ~w_exc;
        w_flush   = w_exc | w_ertn;
        // MEM is flushed alongside us, so its same-cycle offer is dropped
        w_enq     = ms_to_ws_valid & w_allowin & ~w_flush;
    end

    // Lowest-index set exception flag selects ecode/esubcode
    always_comb begin
        w_ecode = '0;
        w_esub  = '0;
        for (int i = EXC_NUM - 1; i >= 0; i--) begin
            if (w_head.exc_flgs[i]) begin
                w_ecode = ECODE_TAB[6*i +: 6];
                w_esub  = ESUB_TAB[9*i +: 9];
            end
        end
    end

    // OR csr_we / ertn across every occupied slot (offset from head < count)
    always_comb begin
        w_blk_we   = 1'b0;
        w_blk_ertn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, c_PTR_W'(c_PTR_W'(i) - r_head)} < r_count) begin
                w_blk_we   = w_blk_we   | r_buf[i].csr_we;
                w_blk_ertn = w_blk_ertn | r_buf[i].ertn;
            end
        end
    end

    // Payload write at the tail; payload is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_buf[r_tail] <= w_in;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_commit) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_enq, w_commit})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Retired-instruction counter; ertn counts, excepting instructions do not
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_commit & ~w_exc) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    // Retire-group outputs are zero whenever nothing commits
    always_comb begin
        ws_allowin        = w_allowin;
        rf_we             = w_rf_we;
        rf_waddr          = w_commit ? w_head.dest      : 5'd0;
        rf_wdata          = w_commit ? w_head.result    : 32'd0;
        csr_we            = w_csr_we;
        csr_wnum          = w_commit ? w_head.csr_wnum  : 14'd0;
        csr_wmask         = w_commit ? w_head.csr_wmask : 32'd0;
        csr_wval          = w_commit ? w_head.csr_wdata : 32'd0;
        wb_exc            = w_exc;
        wb_ecode          = w_commit ? w_ecode          : 6'd0;
        wb_esubcode       = w_commit ? w_esub           : 9'd0;
        wb_pc             = w_commit ? w_head.pc        : 32'd0;
        wb_badvaddr       = w_commit ? w_head.result    : 32'd0;
        ertn_flush        = w_ertn;
        ws_csr_blk_we     = w_blk_we;
        ws_csr_blk_ertn   = w_blk_ertn;
        ws_count          = r_count;
        instret           = r_instret;
        debug_wb_pc       = w_commit ? w_head.pc        : 32'd0;
        debug_wb_rf_wen   = {4{w_rf_we}};
        debug_wb_rf_wnum  = w_commit ? w_head.dest      : 5'd0;
        debug_wb_rf_wdata = w_commit ? w_head.result    : 32'd0;
    end

endmodule
`default_nettype wire
